bp_update_ctrl: RTL and testbench
=================================

BP_UPDATE_CTRL -- requirements
Module: bp_update_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, PC/target width in bits.
REQ-002 Parameter QDEPTH, default 4, update-queue entries (power of two, >=2).
REQ-003 Parameter FLUSH_CYCLES, default 2, cycles flush is held after a redirect.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 res_valid  in  1  execute stage presents a resolved branch.
REQ-007 res_ready  out  1  controller accepts resolution this cycle.
REQ-008 res_pc, res_target  in  ADDR_WIDTH each  branch PC, computed target.
REQ-009 res_taken  in  1  actual branch outcome.
REQ-010 res_pred_addr  in  ADDR_WIDTH  next-PC the predictor gave at fetch.
REQ-011 upd_stall  in  1  predictor update port unavailable this cycle.
REQ-012 upd_enable  out  1  drive predictor enable (one update per cycle).
REQ-013 upd_taken, upd_pc, upd_target  out  1/ADDR_WIDTH/ADDR_WIDTH  update payload to predictor.
REQ-014 redirect_valid  out  1  one-cycle fetch redirect pulse.
REQ-015 redirect_pc  out  ADDR_WIDTH  corrected fetch PC.
REQ-016 flush  out  1  squash wrong-path instructions.
REQ-017 mispredict_cnt  out  16  saturating misprediction count.

Function
REQ-018 Handshake: resolution accepted on a rising edge with res_valid && res_ready.
REQ-019 FSM states IDLE, REDIRECT, FLUSH; REDIRECT lasts 1 cycle, FLUSH lasts FLUSH_CYCLES cycles, then IDLE.
REQ-020 In IDLE, res_ready = !queue_full; in REDIRECT/FLUSH, res_ready = 1 and accepted resolutions are discarded (wrong-path): no enqueue, no compare, no count.
REQ-021 In IDLE an accepted resolution is enqueued {taken, pc, target}.
REQ-022 Actual next PC = res_taken ? res_target : res_pc + 4, truncated modulo 2^ADDR_WIDTH (wrap at top of address space).
REQ-023 Mispredict = accepted in IDLE and actual next PC != res_pred_addr; the FSM moves IDLE->REDIRECT at that edge.
REQ-024 redirect_valid = 1 exactly in REDIRECT; redirect_pc = registered actual next PC of the mispredicting branch.
REQ-025 flush = 1 in REDIRECT and FLUSH (1 + FLUSH_CYCLES cycles total).
REQ-026 Latency: mispredicting branch accepted at edge N -> redirect_valid/flush high in cycle after edge N.
REQ-027 upd_enable = !queue_empty && !upd_stall (combinational on registered queue); payload = queue head; head popped on edge when upd_enable = 1.
REQ-028 Queue updates drain in every FSM state; flush never drops queued (correct-path) updates.
REQ-029 Enqueue-to-upd_enable latency 1 cycle when queue empty and upd_stall = 0.
REQ-030 Simultaneous push and pop: allowed when not full; occupancy unchanged; pointers wrap modulo QDEPTH.
REQ-031 Full in IDLE: res_ready = 0 even if a pop occurs that cycle (no combinational ready-from-pop path).
REQ-032 mispredict_cnt increments by 1 per REQ-023 event, saturates at 16'hFFFF.
REQ-033 Queue order is FIFO; no reordering or coalescing of same-PC updates.

Reset
REQ-034 rst at any edge, including mid-REDIRECT/FLUSH: state IDLE, queue empty (pointers 0), mispredict_cnt 0, redirect_valid 0, redirect_pc 0, flush 0; upd_enable 0 cycle after reset.
REQ-035 During rst = 1, res_ready = 0 and no resolution is accepted.

Structure
REQ-036 State encoding (IDLE/REDIRECT/FLUSH) and default ADDR_WIDTH, QDEPTH, FLUSH_CYCLES constants live in shared common.vh.
REQ-037 Update queue implemented as sub-module bp_upd_fifo (synchronous FIFO, width 1+2*ADDR_WIDTH, depth QDEPTH, full/empty flags).
REQ-038 Outputs to predictor connect directly to bht_btb-style enable/branch_taken/branch_pc/target_addr ports.

Verification
REQ-039 Correct predict: pc=0x010, taken, target=0x040, pred_addr=0x040 -> upd_enable next cycle with payload {1,0x010,0x040}; no redirect; cnt 0.
REQ-040 Mispredict not-taken: pc=0x020, taken=0, pred_addr=0x080 -> redirect_valid 1 cycle, redirect_pc=0x024, flush 3 cycles, cnt=1.
REQ-041 Wrap: pc=0x3FC, taken=0, pred_addr=0x000 -> no mispredict (0x3FC+4 wraps to 0x000).
REQ-042 Backpressure: upd_stall=1, 4 accepted resolutions -> res_ready=0 on 5th; release stall -> 4 updates in FIFO order on consecutive cycles.
REQ-043 Wrong-path squash: mispredict then res_valid during FLUSH -> accepted, not enqueued, cnt unchanged; queued pre-mispredict updates still drain.
REQ-044 Reset mid-FLUSH with 2 queued entries -> next cycle flush=0, upd_enable=0, cnt=0, res_ready=1.

Source files
------------

// File: rtl/bp_update_ctrl_pkg.sv
// rtl/bp_update_ctrl_pkg.sv - shared FSM encoding and default parameters for the branch update controller
package bp_update_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH   = 10;
  localparam int DEF_QDEPTH       = 4;
  localparam int DEF_FLUSH_CYCLES = 2;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REDIRECT = 2'd1;
  localparam logic [1:0] ST_FLUSH    = 2'd2;

endpackage

// File: rtl/bp_upd_fifo.sv
// rtl/bp_upd_fifo.sv - synchronous FIFO holding pending predictor updates
module bp_upd_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;

  logic do_push;
  logic do_pop;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage write; contents need no reset since empty gates every read
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/bp_update_ctrl.sv
// rtl/bp_update_ctrl.sv - branch resolution controller: predictor update queue, redirect and flush
module bp_update_ctrl
  import bp_update_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int QDEPTH       = DEF_QDEPTH,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic [ADDR_WIDTH-1:0] res_pc,
  input  logic [ADDR_WIDTH-1:0] res_target,
  input  logic                  res_taken,
  input  logic [ADDR_WIDTH-1:0] res_pred_addr,
  input  logic                  upd_stall,
  output logic                  upd_enable,
  output logic                  upd_taken,
  output logic [ADDR_WIDTH-1:0] upd_pc,
  output logic [ADDR_WIDTH-1:0] upd_target,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  flush,
  output logic [15:0]           mispredict_cnt
);

  localparam int QW  = 1 + 2 * ADDR_WIDTH;
  localparam int FCW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  logic [1:0]            state;
  logic [FCW-1:0]        flush_left;
  logic                  q_full;
  logic                  q_empty;
  logic [QW-1:0]         q_head;
  logic                  in_idle;
  logic                  accept;
  logic                  enq;
  logic                  mispredict;
  logic [ADDR_WIDTH-1:0] actual_next;

  assign in_idle = (state == ST_IDLE);

  // Ready depends only on registered state and queue flags, never on this cycle's pop
  assign res_ready = !rst && (!in_idle || !q_full);
  assign accept    = res_valid && res_ready;

  // Only correct-path (IDLE) resolutions are queued, compared or counted
  assign enq         = accept && in_idle;
  assign actual_next = res_taken ? res_target : res_pc + ADDR_WIDTH'(4);
  assign mispredict  = enq && (actual_next != res_pred_addr);

  bp_upd_fifo #(
    .WIDTH (QW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (enq),
    .push_data ({res_taken, res_pc, res_target}),
    .pop       (upd_enable),
    .pop_data  (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );

  // Predictor port drains the queue head whenever it is free, in every FSM state
  assign upd_enable = !q_empty && !upd_stall;
  assign upd_taken  = q_head[QW-1];
  assign upd_pc     = q_head[2*ADDR_WIDTH-1:ADDR_WIDTH];
  assign upd_target = q_head[ADDR_WIDTH-1:0];

  assign redirect_valid = (state == ST_REDIRECT);
  assign flush          = !in_idle;

  // Redirect/flush sequencing: one REDIRECT cycle, then FLUSH_CYCLES of FLUSH
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      flush_left <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mispredict) state <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          if (FLUSH_CYCLES > 0) begin
            state      <= ST_FLUSH;
            flush_left <= FCW'(FLUSH_CYCLES - 1);
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (flush_left == '0) state <= ST_IDLE;
          else                  flush_left <= flush_left - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Capture the corrected fetch PC of the mispredicting branch
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_pc <= '0;
    end else if (mispredict) begin
      redirect_pc <= actual_next;
    end
  end

  // Saturating misprediction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict_cnt <= '0;
    end else if (mispredict && (mispredict_cnt != 16'hFFFF)) begin
      mispredict_cnt <= mispredict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// tb/tb_bp_update_ctrl.sv - self-checking bench for bp_update_ctrl
module tb_bp_update_ctrl;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          res_valid;
  logic          res_ready;
  logic [AW-1:0] res_pc;
  logic [AW-1:0] res_target;
  logic          res_taken;
  logic [AW-1:0] res_pred_addr;
  logic          upd_stall;
  logic          upd_enable;
  logic          upd_taken;
  logic [AW-1:0] upd_pc;
  logic [AW-1:0] upd_target;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          flush;
  logic [15:0]   mispredict_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [2*AW:0] sb[$];

  typedef struct {
    logic [AW-1:0] pc;
    logic [AW-1:0] target;
    logic          taken;
    logic [AW-1:0] pred;
    logic          exp_mis;
    logic [AW-1:0] exp_rpc;
  } vec_t;

  vec_t vecs[6];

  bp_update_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_pc         (res_pc),
    .res_target     (res_target),
    .res_taken      (res_taken),
    .res_pred_addr  (res_pred_addr),
    .upd_stall      (upd_stall),
    .upd_enable     (upd_enable),
    .upd_taken      (upd_taken),
    .upd_pc         (upd_pc),
    .upd_target     (upd_target),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .mispredict_cnt (mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every update the DUT issues must match the oldest expected one
  always @(negedge clk) begin
    if (!rst && upd_enable) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL upd_unexpected: got {%0b,0x%0h,0x%0h} expected none", upd_taken, upd_pc, upd_target);
      end else begin
        logic [2*AW:0] e;
        e = sb.pop_front();
        if ({upd_taken, upd_pc, upd_target} !== e) begin
          n_err++;
          $display("FAIL upd_payload: got 0x%0h expected 0x%0h", {upd_taken, upd_pc, upd_target}, e);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [AW-1:0] pc, input logic [AW-1:0] tgt, input logic tk,
                      input logic [AW-1:0] pred, input logic exp_enq);
    int waited = 0;
    res_valid     = 1'b1;
    res_pc        = pc;
    res_target    = tgt;
    res_taken     = tk;
    res_pred_addr = pred;
    @(negedge clk);
    while (!res_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!res_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got res_ready=0 expected 1 within 20 cycles");
    end
    @(posedge clk);
    if (exp_enq) sb.push_back({tk, pc, tgt});
    #1;
    res_valid = 1'b0;
  endtask

  // Checks the full redirect/flush window; entered at posedge+1 after the mispredict edge
  task automatic check_redirect(input logic [AW-1:0] rpc, input logic [15:0] cnt);
    check("redir_valid_c0", 32'(redirect_valid), 32'd1);
    check("redir_pc", 32'(redirect_pc), 32'(rpc));
    check("flush_c0", 32'(flush), 32'd1);
    check("cnt", 32'(mispredict_cnt), 32'(cnt));
    @(posedge clk); #1;
    check("redir_valid_c1", 32'(redirect_valid), 32'd0);
    check("flush_c1", 32'(flush), 32'd1);
    @(posedge clk); #1;
    check("flush_c2", 32'(flush), 32'd1);
    @(posedge clk); #1;
    check("flush_c3", 32'(flush), 32'd0);
  endtask

  task automatic drain_wait(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    vecs[0] = '{10'h010, 10'h040, 1'b1, 10'h040, 1'b0, 10'h000};
    vecs[1] = '{10'h020, 10'h000, 1'b0, 10'h080, 1'b1, 10'h024};
    vecs[2] = '{10'h3FC, 10'h100, 1'b0, 10'h000, 1'b0, 10'h000};
    vecs[3] = '{10'h100, 10'h200, 1'b1, 10'h104, 1'b1, 10'h200};
    vecs[4] = '{10'h3FC, 10'h3F0, 1'b1, 10'h000, 1'b1, 10'h3F0};
    vecs[5] = '{10'h050, 10'h0AA, 1'b0, 10'h054, 1'b0, 10'h000};

    rst = 1'b1; res_valid = 1'b0; res_pc = '0; res_target = '0;
    res_taken = 1'b0; res_pred_addr = '0; upd_stall = 1'b0;
    @(posedge clk); #1;
    check("ready_in_reset", 32'(res_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_redir", 32'(redirect_valid), 32'd0);
    check("rst_rpc", 32'(redirect_pc), 32'd0);
    check("rst_cnt", 32'(mispredict_cnt), 32'd0);
    check("rst_upd_en", 32'(upd_enable), 32'd0);
    check("rst_ready", 32'(res_ready), 32'd1);
    @(posedge clk); #1;

    // Table-driven single resolutions
    begin
      logic [15:0] cnt = 16'd0;
      for (int i = 0; i < 6; i++) begin
        send(vecs[i].pc, vecs[i].target, vecs[i].taken, vecs[i].pred, 1'b1);
        check("upd_en_next", 32'(upd_enable), 32'd1);
        if (vecs[i].exp_mis) begin
          cnt++;
          check_redirect(vecs[i].exp_rpc, cnt);
        end else begin
          check("no_redir", 32'(redirect_valid), 32'd0);
          check("no_flush", 32'(flush), 32'd0);
          check("cnt_hold", 32'(mispredict_cnt), 32'(cnt));
        end
        drain_wait(2);
      end
    end

    // Backpressure: fill the queue, confirm full stalls ready even while draining
    upd_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [AW-1:0] p;
      p = AW'(10'h200 + 10'(i * 8));
      send(p, AW'(p + 10'h10), 1'b1, AW'(p + 10'h10), 1'b1);
    end
    check("full_ready", 32'(res_ready), 32'd0);
    check("stall_upd_en", 32'(upd_enable), 32'd0);
    res_valid = 1'b1; res_pc = 10'h300; res_target = 10'h310; res_taken = 1'b1; res_pred_addr = 10'h310;
    @(posedge clk); #1;
    res_valid = 1'b0;
    upd_stall = 1'b0;
    #1;
    check("full_pop_ready", 32'(res_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("drain_en", 32'(upd_enable), 32'd1);
      @(posedge clk); #1;
    end
    check("drain_done", 32'(upd_enable), 32'd0);
    check("drain_sb", 32'(sb.size()), 32'd0);

    // Wrong-path squash during REDIRECT/FLUSH; queued updates still drain
    upd_stall = 1'b1;
    send(10'h060, 10'h070, 1'b1, 10'h070, 1'b1);
    send(10'h080, 10'h090, 1'b0, 10'h084, 1'b1);
    send(10'h020, 10'h000, 1'b0, 10'h080, 1'b1);
    check("sq_redir", 32'(redirect_valid), 32'd1);
    send(10'h0C0, 10'h0D0, 1'b1, 10'h000, 1'b0);
    send(10'h0E0, 10'h0F0, 1'b0, 10'h000, 1'b0);
    check("sq_cnt", 32'(mispredict_cnt), 32'd4);
    upd_stall = 1'b0;
    drain_wait(6);
    check("sq_cnt_after", 32'(mispredict_cnt), 32'd4);
    check("sq_idle", 32'(flush), 32'd0);

    // Reset mid-FLUSH with two queued entries
    upd_stall = 1'b1;
    send(10'h140, 10'h150, 1'b1, 10'h150, 1'b1);
    send(10'h160, 10'h170, 1'b1, 10'h164, 1'b1);
    @(posedge clk); #1;
    check("pre_rst_flush", 32'(flush), 32'd1);
    rst = 1'b1;
    upd_stall = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mr_flush", 32'(flush), 32'd0);
    check("mr_upd_en", 32'(upd_enable), 32'd0);
    check("mr_cnt", 32'(mispredict_cnt), 32'd0);
    check("mr_ready", 32'(res_ready), 32'd1);
    check("mr_redir", 32'(redirect_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
